// File: rtl/case4_result_reader_if.sv
// Result stream from case4_result_reader to its consumer.
// Each beat carries a word, its (j, a) indices and a last flag.
interface case4_result_reader_if #(
  parameter int DATA_W  = 16,
  parameter int J_WIDTH = 3,
  parameter int A_WIDTH = 3
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [J_WIDTH-1:0] out_j;
  logic [A_WIDTH-1:0] out_a;
  logic              out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_j,
    output out_a,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_j,
    input  out_a,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/case4_result_reader.sv
// Reads the J x A case4 result matrix from a sync RAM
// and streams it out over valid/ready with (j, a, last) tags.
module case4_result_reader #(
  parameter int J      = 4,
  parameter int A      = 4,
  parameter int DATA_W = 16,
  localparam int J_WIDTH = $clog2(J) + 1,
  localparam int A_WIDTH = $clog2(A) + 1,
  localparam int ADDR_W  = $clog2(J * A)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  case4_result_reader_if.master strm
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    FIN
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [J_WIDTH-1:0] j;
    logic [A_WIDTH-1:0] a;
    logic               last;
  } beat_t;

  state_t state_q;
  state_t state_d;

  logic [J_WIDTH-1:0] j_q;
  logic [A_WIDTH-1:0] a_q;
  logic [ADDR_W-1:0]  addr_q;

  logic               fl_q;
  logic [J_WIDTH-1:0] fl_j_q;
  logic [A_WIDTH-1:0] fl_a_q;
  logic               fl_last_q;

  beat_t      fifo_q [2];
  logic       wr_q;
  logic       rd_q;
  logic [1:0] cnt_q;

  beat_t head;
  logic  pop;
  logic  push;
  logic  is_last;
  logic  can_issue;

  assign head    = fifo_q[rd_q];
  assign pop     = (cnt_q != 2'd0) && strm.out_ready;
  assign push    = fl_q;
  assign is_last = (j_q == J_WIDTH'(J - 1)) &&
                   (a_q == A_WIDTH'(A - 1));

  // Queued plus in-flight words must stay within the 2-entry FIFO.
  assign can_issue = ({1'b0, cnt_q} + {2'b0, fl_q}) <
                     (3'd2 + {2'b0, pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: if (mem_rd_en && is_last) state_d = DRAIN;
      DRAIN: if (pop && head.last) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    unique case (state_q)
      FETCH: begin
        busy      = 1'b1;
        mem_rd_en = can_issue;
      end
      DRAIN: busy = 1'b1;
      FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q    <= '0;
      a_q    <= '0;
      addr_q <= '0;
    end else if (state_q == IDLE && start) begin
      j_q    <= '0;
      a_q    <= '0;
      addr_q <= '0;
    end else if (mem_rd_en && !is_last) begin
      addr_q <= addr_q + 1'b1;
      if (a_q == A_WIDTH'(A - 1)) begin
        a_q <= '0;
        j_q <= j_q + 1'b1;
      end else begin
        a_q <= a_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_q      <= 1'b0;
      fl_j_q    <= '0;
      fl_a_q    <= '0;
      fl_last_q <= 1'b0;
    end else begin
      fl_q <= mem_rd_en;
      if (mem_rd_en) begin
        fl_j_q    <= j_q;
        fl_a_q    <= a_q;
        fl_last_q <= is_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= '{data: mem_rd_data,
                          j:    fl_j_q,
                          a:    fl_a_q,
                          last: fl_last_q};
        wr_q <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      if (push && !pop)      cnt_q <= cnt_q + 2'd1;
      else if (pop && !push) cnt_q <= cnt_q - 2'd1;
    end
  end

  assign mem_rd_addr    = addr_q;
  assign strm.out_valid = (cnt_q != 2'd0);
  assign strm.out_data  = head.data;
  assign strm.out_j     = head.j;
  assign strm.out_a     = head.a;
  assign strm.out_last  = head.last;

endmodule

// File: tb/tb_case4_result_reader.sv
// Directed bench for case4_result_reader: 4x4 main DUT
// plus a 2x3 instance for the parameter sweep.
module tb_case4_result_reader;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic done;
  logic mem_rd_en;
  logic [3:0] mem_rd_addr;
  logic [15:0] mem_rd_data;

  logic start2;
  logic busy2;
  logic done2;
  logic mem_rd_en2;
  logic [2:0] mem_rd_addr2;
  logic [15:0] mem_rd_data2;

  always #5 clk = ~clk;

  case4_result_reader_if #(.DATA_W(16), .J_WIDTH(3), .A_WIDTH(3)) o1 ();
  case4_result_reader_if #(.DATA_W(16), .J_WIDTH(2), .A_WIDTH(3)) o2 ();

  case4_result_reader #(.J(4), .A(4), .DATA_W(16)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .strm        (o1)
  );

  case4_result_reader #(.J(2), .A(3), .DATA_W(16)) u_dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start2),
    .busy        (busy2),
    .done        (done2),
    .mem_rd_en   (mem_rd_en2),
    .mem_rd_addr (mem_rd_addr2),
    .mem_rd_data (mem_rd_data2),
    .strm        (o2)
  );

  // Sync RAMs holding 0x0100*j + a at address j*A + a.
  always_ff @(posedge clk) begin
    if (mem_rd_en)
      mem_rd_data <= 16'((int'(mem_rd_addr) / 4) * 256 +
                         int'(mem_rd_addr) % 4);
    if (mem_rd_en2)
      mem_rd_data2 <= 16'((int'(mem_rd_addr2) / 3) * 256 +
                          int'(mem_rd_addr2) % 3);
  end

  typedef struct {
    int j;
    int a;
    bit last;
    int data;
  } beat_t;

  beat_t q1[$];
  beat_t q2[$];
  int done_cnt;
  int done2_cnt;
  int rd_cnt;
  int hold_err;
  bit hold_pend;
  logic [15:0] hold_d;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    if (rst_n) begin
      if (o1.out_valid && o1.out_ready)
        q1.push_back('{int'(o1.out_j), int'(o1.out_a),
                       o1.out_last, int'(o1.out_data)});
      if (o2.out_valid && o2.out_ready)
        q2.push_back('{int'(o2.out_j), int'(o2.out_a),
                       o2.out_last, int'(o2.out_data)});
      if (done) done_cnt++;
      if (done2) done2_cnt++;
      if (mem_rd_en) rd_cnt++;
      if (hold_pend &&
          !(o1.out_valid && o1.out_data == hold_d))
        hold_err++;
      hold_pend = o1.out_valid && !o1.out_ready;
      hold_d = o1.out_data;
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    q1.delete();
    q2.delete();
    done_cnt = 0;
    done2_cnt = 0;
    rd_cnt = 0;
    hold_err = 0;
    hold_pend = 0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      o1.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    o1.out_ready = 1'b1;
  endtask

  task automatic check_run(input string tag);
    int errs = 0;
    int lasts = 0;
    foreach (q1[i]) begin
      if (q1[i].j != i / 4 || q1[i].a != i % 4) errs++;
      if (q1[i].data != (i / 4) * 256 + i % 4) errs++;
      if (q1[i].last != (i == 15)) errs++;
      if (q1[i].last) lasts++;
    end
    chk({tag, "_beats"}, q1.size(), 16);
    chk({tag, "_order"}, errs, 0);
    chk({tag, "_lasts"}, lasts, 1);
    chk({tag, "_dones"}, done_cnt, 1);
    chk({tag, "_hold"}, hold_err, 0);
  endtask

  initial begin
    bit ev;
    int w;
    int bad;
    int errs;
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    o1.out_ready = 1'b0;
    o2.out_ready = 1'b1;
    clear();

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", o1.out_valid, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_rd_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_data", o1.out_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full-rate readout with cycle-exact timing.
    start = 1'b1;
    o1.out_ready = 1'b1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      ev = (k >= 1 && k <= 16);
      chk($sformatf("t1_rd_en_c%0d", k), mem_rd_en, ev);
      if (ev) chk($sformatf("t1_addr_c%0d", k), mem_rd_addr, k - 1);
      ev = (k >= 3 && k <= 18);
      chk($sformatf("t1_valid_c%0d", k), o1.out_valid, ev);
      if (ev) begin
        chk($sformatf("t1_data_c%0d", k), o1.out_data,
            ((k - 3) / 4) * 256 + (k - 3) % 4);
        chk($sformatf("t1_last_c%0d", k), o1.out_last, k == 18);
      end
      chk($sformatf("t1_done_c%0d", k), done, k == 19);
      chk($sformatf("t1_busy_c%0d", k), busy, k >= 1 && k <= 18);
      @(posedge clk);
      #1;
      start = 1'b0;
    end

    // Backpressure from the first presented beat.
    clear();
    o1.out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    w = 0;
    while (!o1.out_valid && w < 10) begin
      step();
      w++;
    end
    chk("bp_first_valid", o1.out_valid, 1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (!(o1.out_valid && o1.out_data == 16'h0000)) bad++;
      step();
    end
    chk("bp_stall_stable", bad, 0);
    chk("bp_reads_le3", rd_cnt <= 3, 1);
    wait_done(200, 1'b0);
    check_run("bp");

    // Random backpressure, back-to-back runs.
    for (int r = 0; r < 5; r++) begin
      clear();
      start = 1'b1;
      o1.out_ready = 1'($urandom_range(0, 1));
      step();
      start = 1'b0;
      wait_done(300, 1'b1);
      check_run($sformatf("rnd%0d", r));
    end

    // start re-asserted in cycle 5 and in FIN.
    clear();
    o1.out_ready = 1'b1;
    for (int k = 0; k < 26; k++) begin
      start = (k == 0 || k == 5 || k == 19);
      step();
    end
    start = 1'b0;
    check_run("ign");
    chk("ign_reads", rd_cnt, 16);
    chk("ign_busy_after", busy, 0);

    // Reset mid-stream.
    clear();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", o1.out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rd_en", mem_rd_en, 0);
    chk("mrst_outs",
        {mem_rd_addr, o1.out_data, o1.out_j, o1.out_a,
         o1.out_last, done}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, 1'b0);
    check_run("post_rst");

    // 2x3 instance.
    clear();
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (14) step();
    errs = 0;
    foreach (q2[i]) begin
      if (q2[i].j != i / 3 || q2[i].a != i % 3) errs++;
      if (q2[i].data != (i / 3) * 256 + i % 3) errs++;
      if (q2[i].last != (i == 5)) errs++;
    end
    chk("sw_beats", q2.size(), 6);
    chk("sw_order", errs, 0);
    chk("sw_dones", done2_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
